// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer:
// opcodes, datapath mux encodings, state encoding and the control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        EXEC    = 4'd7,
        RTYPEWB = 4'd8,
        BRANCH  = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        JUMP    = 4'd12
    } ctrl_state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
    } ctrl_word_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Moore decode of the sequencer state into the datapath control word.
// Write enables in memory-facing states are qualified by mem_ready.
module ctrl_out_decode
    import mips_pkg::*;
(
    input  ctrl_state_t state,
    input  logic        mem_ready,
    output ctrl_word_t  ctrl
);

    // Control word per state; everything not named in a state stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memread  = 1'b1;
                ctrl.alusrcb  = SRCB_FOUR;
                ctrl.aluop    = ALUOP_ADD;
                ctrl.pcsource = PCSRC_ALU;
                ctrl.irwrite  = mem_ready;
                ctrl.pcwrite  = mem_ready;
            end
            DECODE: begin
                ctrl.alusrcb = SRCB_IMM_SH2;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = mem_ready;
            end
            EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_RT;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = SRCB_RT;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PCSRC_ALUOUT;
            end
            ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer. Steps the shared datapath one state
// per clock, holds memory states until mem_ready, counts retired
// instructions and flags undecodable opcodes.
//
// state   | meaning
// IDLE    | after reset, all controls off
// FETCH   | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE  | register read, branch target precompute, dispatch by opcode
// MEMADR  | load/store effective address
// MEMRD   | load data read, held until mem_ready
// MEMWB   | load data written to rt
// MEMWR   | store data write, held until mem_ready
// EXEC    | R-type ALU operation
// RTYPEWB | R-type result written to rd
// BRANCH  | BEQ compare, PC <= target when zero
// ADDIEX  | ADDI ALU operation
// ADDIWB  | ADDI result written to rt
// JUMP    | PC <= jump target
module multicycle_control
    import mips_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             pc_en,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    ctrl_word_t  ctrl;
    logic        mem_rdy;
    logic        retire;

    // Without the handshake every memory access completes in one cycle.
    assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // State register; reset forces IDLE, which decodes to all-zero controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and illegal opcode flag.
    always_comb begin
        state_d    = state_q;
        illegal_op = 1'b0;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (mem_rdy) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (mem_rdy) state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (mem_rdy) state_d = FETCH;
            EXEC:    state_d = RTYPEWB;
            RTYPEWB: state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // An instruction retires in its final state; a store only once its write lands.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            MEMWB, RTYPEWB, ADDIWB, BRANCH, JUMP: retire = 1'b1;
            MEMWR:   retire = mem_rdy;
            default: retire = 1'b0;
        endcase
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + CNT_ONE;
        end
    end

    ctrl_out_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_rdy),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pcwrite;
    assign PCWriteCond = ctrl.pcwritecond;
    assign pc_en       = ctrl.pcwrite | (ctrl.pcwritecond & zero);
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.memread;
    assign MemWrite    = ctrl.memwrite;
    assign IRWrite     = ctrl.irwrite;
    assign MemtoReg    = ctrl.memtoreg;
    assign RegDst      = ctrl.regdst;
    assign RegWrite    = ctrl.regwrite;
    assign ALUSrcA     = ctrl.alusrca;
    assign ALUSrcB     = ctrl.alusrcb;
    assign ALUOp       = ctrl.aluop;
    assign PCSource    = ctrl.pcsource;
    assign state       = state_q;

endmodule
